// File: rtl/ff_input_cond.sv
// Conditions raw board switches: 2-flop sync, tick-paced debounce, one-shot coin pulses.
// Latency: 2 cycles + DB_TICKS ticks + 1 cycle; no handshake, outputs are registered levels.
module ff_input_cond #(
  parameter int unsigned TICK_DIV   = 12000,
  parameter int unsigned DB_TICKS   = 8,
  parameter int unsigned COIN_TICKS = 40,
  parameter logic [9:0]  IDLE       = 10'h3FF,
  parameter logic [9:0]  COIN_MASK  = 10'b0011001000
) (
  input  logic        clk12m,
  input  logic        reset_n,
  input  logic [9:0]  sw_in,
  input  logic [8:1]  sw1_in,
  output logic [9:0]  sw_o,
  output logic [8:1]  sw1_o,
  output logic        tick_o
);

  localparam int NB = 18;
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW = $clog2(DB_TICKS + 1);
  localparam int CW = $clog2(COIN_TICKS + 1);
  localparam logic [NB-1:0] IDLE_ALL = {8'hFF, IDLE};

  typedef enum logic [1:0] {WAIT = 2'd0, PULSE = 2'd1, HOLD = 2'd2} coin_st_t;

  logic [PW-1:0] presc;
  logic [PW-1:0] presc_nxt;
  logic          tick;

  logic [NB-1:0] raw;
  logic [NB-1:0] s1;
  logic [NB-1:0] s2;
  logic [NB-1:0] stable;
  logic [NB-1:0] acc;
  logic [DW-1:0] db_cnt [NB];

  coin_st_t      coin_st  [10];
  logic [CW-1:0] coin_cnt [10];
  logic [9:0]    coin_out;

  // tick is registered so it lines up exactly with presc == TICK_DIV-1
  assign presc_nxt = tick ? '0 : presc + PW'(1);

  always_ff @(posedge clk12m) begin
    if (!reset_n) begin
      presc <= '0;
      tick  <= 1'b0;
    end else begin
      presc <= presc_nxt;
      tick  <= (presc_nxt == PW'(TICK_DIV - 1));
    end
  end

  assign tick_o = tick;
  assign raw    = {sw1_in, sw_in};

  always_comb begin
    acc = '0;
    for (int i = 0; i < NB; i++) begin
      acc[i] = tick && (s2[i] != stable[i]) && (db_cnt[i] == DW'(DB_TICKS - 1));
    end
  end

  always_ff @(posedge clk12m) begin
    if (!reset_n) begin
      s1     <= IDLE_ALL;
      s2     <= IDLE_ALL;
      stable <= IDLE_ALL;
      for (int i = 0; i < NB; i++) db_cnt[i] <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      for (int i = 0; i < NB; i++) begin
        // any single cycle of agreement throws away the accumulated count
        if (s2[i] == stable[i]) begin
          db_cnt[i] <= '0;
        end else if (acc[i]) begin
          stable[i] <= s2[i];
          db_cnt[i] <= '0;
        end else if (tick) begin
          db_cnt[i] <= db_cnt[i] + DW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk12m) begin
    if (!reset_n) begin
      coin_out <= IDLE;
      for (int i = 0; i < 10; i++) begin
        coin_st[i]  <= WAIT;
        coin_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 10; i++) begin
        if (COIN_MASK[i]) begin
          case (coin_st[i])
            WAIT: begin
              if (acc[i] && (s2[i] != IDLE[i])) begin
                coin_st[i]  <= PULSE;
                coin_out[i] <= ~IDLE[i];
                coin_cnt[i] <= '0;
              end
            end
            PULSE: begin
              // pulse length is fixed; input release here has no effect
              if (tick) begin
                if (coin_cnt[i] == CW'(COIN_TICKS - 1)) begin
                  coin_out[i] <= IDLE[i];
                  coin_st[i]  <= (stable[i] == IDLE[i]) ? WAIT : HOLD;
                end else begin
                  coin_cnt[i] <= coin_cnt[i] + CW'(1);
                end
              end
            end
            HOLD: begin
              if (stable[i] == IDLE[i]) coin_st[i] <= WAIT;
            end
            default: coin_st[i] <= WAIT;
          endcase
        end
      end
    end
  end

  assign sw_o  = (coin_out & COIN_MASK) | (stable[9:0] & ~COIN_MASK);
  assign sw1_o = stable[17:10];

endmodule
